// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: 16x16 -> 32 shift-and-add multiply sequencer driving an external 16-bit ADD unit.
// Latency 16 cycles unsigned (18 signed with MUL_SIGNED_EN); holds the product until out_ready.
module mul_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  output logic        add_sign,
  input  logic [15:0] add_sum,
  input  logic        add_cout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
`ifdef MUL_SIGNED_EN
    S_FIXA = 3'd2,
    S_FIXB = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_a_reg;
  logic [15:0] r_b_reg;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [3:0]  r_cnt;
  logic        r_sgn;

  logic [15:0] w_a_nx;
  logic [15:0] w_b_nx;
  logic [15:0] w_hi_nx;
  logic [15:0] w_lo_nx;
  logic [3:0]  w_cnt_nx;
  logic        w_sgn_nx;
  logic        w_sgn_in;

`ifdef MUL_SIGNED_EN
  assign w_sgn_in = in_signed;
`else
  // Without signed support the operand sign flag and original multiplier are never consulted.
  assign w_sgn_in = 1'b0;
  logic [17:0] w_unused_nosign;
  assign w_unused_nosign = {in_signed, r_sgn, r_b_reg};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_reg <= 16'd0;
      r_b_reg <= 16'd0;
      r_hi    <= 16'd0;
      r_lo    <= 16'd0;
      r_cnt   <= 4'd0;
      r_sgn   <= 1'b0;
    end else begin
      r_a_reg <= w_a_nx;
      r_b_reg <= w_b_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_cnt   <= w_cnt_nx;
      r_sgn   <= w_sgn_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a_reg;
    w_b_nx     = r_b_reg;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_cnt_nx   = r_cnt;
    w_sgn_nx   = r_sgn;
    add_a      = 16'd0;
    add_b      = 16'd0;
    add_cin    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_a_nx     = in_a;
          w_b_nx     = in_b;
          w_lo_nx    = in_b;
          w_hi_nx    = 16'd0;
          w_cnt_nx   = 4'd0;
          w_sgn_nx   = w_sgn_in;
          w_state_nx = S_MUL;
        end
      end

      S_MUL: begin
        add_a = r_hi;
        add_b = r_a_reg;
        // Multiplier bits shift out of lo while product bits shift in from hi.
        if (r_lo[0]) begin
          {w_hi_nx, w_lo_nx} = {add_cout, add_sum, r_lo[15:1]};
        end else begin
          {w_hi_nx, w_lo_nx} = {1'b0, r_hi, r_lo[15:1]};
        end
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
`ifdef MUL_SIGNED_EN
          w_state_nx = r_sgn ? S_FIXA : S_DONE;
`else
          w_state_nx = S_DONE;
`endif
        end
      end

`ifdef MUL_SIGNED_EN
      // Two's-complement correction of the upper half: subtract b if a<0, then a if b<0.
      S_FIXA: begin
        add_a   = r_hi;
        add_b   = ~r_b_reg;
        add_cin = 1'b1;
        if (r_a_reg[15]) begin
          w_hi_nx = add_sum;
        end
        w_state_nx = S_FIXB;
      end

      S_FIXB: begin
        add_a   = r_hi;
        add_b   = ~r_a_reg;
        add_cin = 1'b1;
        if (r_b_reg[15]) begin
          w_hi_nx = add_sum;
        end
        w_state_nx = S_DONE;
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign product   = {r_hi, r_lo};
  assign add_sign  = 1'b0;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle 16x16 multiply sequencer that produces a 32-bit product by repeatedly driving a shared 16-bit ADD unit in a shift-and-add loop. It sits beside the execute-stage ALU. It owns the ADD unit's operand/carry-in inputs while busy, and exchanges operands and results with the pipeline over a valid/ready handshake. The ADD unit itself is external; this block only sequences it.

## Interface
Parameters:
- none (width fixed at 16-bit operands, 32-bit product)

Ports:
- `clk` input 1: single clock; all state updates on rising edge
- `rst_n` input 1: synchronous, active-low reset
- `in_valid` input 1: operands present
- `in_ready` output 1: block can accept operands (high only in IDLE)
- `in_a` input 16: multiplicand
- `in_b` input 16: multiplier
- `in_signed` input 1: 1 = two's-complement operands (honored only with `MUL_SIGNED_EN`)
- `out_valid` output 1: product available
- `out_ready` input 1: consumer takes product
- `product` output 32: result, {hi, lo}
- `add_a` output 16: to ADD unit operand A
- `add_b` output 16: to ADD unit operand B
- `add_cin` output 1: to ADD unit carry-in
- `add_sign` output 1: to ADD unit sign select; always 0 (carry-out used)
- `add_sum` input 16: from ADD unit result
- `add_cout` input 1: from ADD unit carry-out

## Operation
- Registers: `a_reg`[16], `b_reg`[16] (original operands), `hi`[16], `lo`[16], `cnt`[4], `sgn`[1], state.
- IDLE: `in_ready`=1. On `in_valid & in_ready`: `a_reg`<=`in_a`, `b_reg`<=`in_b`, `lo`<=`in_b`, `hi`<=0, `cnt`<=0, `sgn`<=`in_signed` (forced 0 without macro); go MUL.
- MUL:
  - `add_a`=`hi`, `add_b`=`a_reg`, `add_cin`=0.
  - If `lo[0]`: {hi,lo} <= {add_cout, add_sum, lo[15:1]}; else {hi,lo} <= {1'b0, hi, lo[15:1]}.
  - `cnt`++. When `cnt`==15, go FIXA if `sgn`, else DONE.
- FIXA: `add_a`=`hi`, `add_b`=~`b_reg`, `add_cin`=1. If `a_reg[15]`, `hi`<=`add_sum`; else `hi` unchanged. Go FIXB.
- FIXB: `add_a`=`hi`, `add_b`=~`a_reg`, `add_cin`=1. If `b_reg[15]`, `hi`<=`add_sum`. Go DONE.
- DONE: `out_valid`=1, `product`={hi,lo} held stable. On `out_ready`, go IDLE.
- The MUL, FIXA and FIXB rules above are the arithmetic: the upper half is corrected mod 2^16, and the lower half is never corrected.
- Outside MUL/FIXA/FIXB: `add_a`=`add_b`=0, `add_cin`=0.
- `product` is the {hi,lo} register at all times. It is only meaningful while `out_valid`=1.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State IDLE, all registers 0.
  - `in_ready`=1, `out_valid`=0, `product`=0, `add_*`=0.
- Reset mid-operation: in-flight operation discarded; IDLE on the next cycle; no `out_valid` pulse.
- Latency: input handshake at edge 0.
  - Unsigned: `out_valid` rises after edge 16.
  - Signed: `out_valid` rises after edge 18.
  - Fixed latency, independent of operand values.
- `in_ready` is combinational from state only; it never depends on `in_valid`.
- `out_valid` holds until `out_ready`. Backpressure is unbounded.
- No overlap: the next input handshake is possible at the earliest one cycle after the output handshake edge (the first cycle in IDLE).
- `in_valid` while busy is ignored; the source must hold operands until `in_ready`.
- ADD unit is combinational; `add_sum`/`add_cout` are sampled at the same edge the operands are driven.

## Configuration
- `MUL_SIGNED_EN` defined:
  - FIXA/FIXB states exist.
  - `in_signed` honored; signed ops take 18 cycles.
- Not defined:
  - FIXA/FIXB removed; `sgn` forced 0.
  - `in_signed` ignored; every operation is unsigned, 16 cycles.

## Test plan
- Reset, then 0x0003 x 0x0005 unsigned -> `product`=0x0000000F, `out_valid` 16 cycles after accept.
- 0xFFFF x 0xFFFF unsigned -> 0xFFFE0001; the carry-out path is exercised every iteration.
- Signed (macro on), 0xFFFF x 0xFFFF -> 0x00000001 at 18 cycles. Signed 0x8000 x 0x0002 -> 0xFFFF0000.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `product` stable, `in_ready`=0 throughout, `in_valid` pulses ignored.
- Assert `rst_n`=0 for one edge at MUL cycle 8 -> next cycle IDLE, `in_ready`=1, `out_valid`=0. A following 7 x 9 returns 0x0000003F.
- Macro off, `in_signed`=1, 0xFFFF x 0x0002 -> 0x0001FFFE at 16 cycles.
